// File: rtl/forward_hazard_if.sv
// forward_hazard_if: ID-stage tags, branch resolution and forwarding/hazard controls
interface forward_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_branch_taken;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic              stall;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread, ex_branch_taken,
    input  ForwardA, ForwardB, stall, flush, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread, ex_branch_taken,
    output ForwardA, ForwardB, stall, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl: EX/MEM/WB tag pipeline driving operand forwarding, load-use stall and branch flush
module forward_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  forward_hazard_if.slave bus
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } tag_t;
  typedef struct packed {
    tag_t              t;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
  } ex_t;
  ex_t              ex_q, ex_d;
  tag_t             mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hazard, stall, flush;
  // A load sitting in MEM has no data yet, so only WB may supply load results
  function automatic logic [1:0] fwd(input ex_t e, input tag_t m, input tag_t w, input logic u, input logic [REG_AW-1:0] rs);
    return (!e.t.v || !u) ? 2'b00 :
           (m.v && m.rw && !m.mr && m.rd != '0 && m.rd == rs) ? 2'b10 :
           (w.v && w.rw && w.rd != '0 && w.rd == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    hazard = ex_q.t.v & ex_q.t.mr & ex_q.t.rw & (ex_q.t.rd != '0) & bus.id_valid &
             ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.t.rd)) | (bus.id_use_rs2 & (bus.id_rs2 == ex_q.t.rd)));
    flush = bus.ex_branch_taken & ~rst;
    stall = hazard & ~bus.ex_branch_taken & ~rst;
    ex_d = (flush | stall | ~bus.id_valid) ? '0 :
           {1'b1, bus.id_rd, bus.id_regwrite, bus.id_memread, bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2};
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q.t;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign bus.ForwardA  = fwd(ex_q, mem_q, wb_q, ex_q.u1, ex_q.rs1);
  assign bus.ForwardB  = fwd(ex_q, mem_q, wb_q, ex_q.u2, ex_q.rs2);
  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb_forward_hazard_ctrl: scenario tasks with a scoreboard of per-cycle {ForwardA,ForwardB,stall,flush}
module tb_forward_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  forward_hazard_if #(.REG_AW(5), .CNT_W(16)) bus();
  forward_hazard_if #(.REG_AW(5), .CNT_W(2))  bus2();
  forward_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  forward_hazard_ctrl #(.REG_AW(5), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));
  typedef struct {
    logic       v;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, rw, mr, br;
    logic [5:0] want;
  } row_t;
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] sb[$];
  function automatic row_t ins(input logic [4:0] rd, rs1, rs2, input logic u1, u2, rw, mr, br, input logic [5:0] want);
    row_t r;
    r.v = 1'b1; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.u1 = u1; r.u2 = u2; r.rw = rw; r.mr = mr; r.br = br; r.want = want;
    return r;
  endfunction
  function automatic row_t nop(input logic br, input logic [5:0] want);
    row_t r;
    r = ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, br, want);
    r.v = 1'b0;
    return r;
  endfunction
  task automatic drive(input row_t r);
    bus.id_valid = r.v; bus.id_rd = r.rd; bus.id_rs1 = r.rs1; bus.id_rs2 = r.rs2;
    bus.id_use_rs1 = r.u1; bus.id_use_rs2 = r.u2; bus.id_regwrite = r.rw;
    bus.id_memread = r.mr; bus.ex_branch_taken = r.br;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      drive(nop(1'b0, 6'd0));
      tick();
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(nop(1'b0, 6'd0));
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({bus.ForwardA, bus.ForwardB, bus.stall, bus.flush} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 000000", {bus.ForwardA, bus.ForwardB, bus.stall, bus.flush});
    end
    n_cmp++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask
  task automatic test_forward();
    row_t q[$];
    logic [5:0] e, o;
    idle(3);
    q.push_back(ins(5, 1, 2, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(8, 5, 6, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(nop(0, 6'b10_00_00));
    repeat (3) q.push_back(nop(0, 6'b00_00_00));
    q.push_back(ins(5, 1, 2, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(nop(0, 6'b00_00_00));
    q.push_back(ins(8, 3, 5, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(nop(0, 6'b00_01_00));
    repeat (2) q.push_back(nop(0, 6'b00_00_00));
    q.push_back(ins(5, 1, 2, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(5, 3, 4, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(8, 5, 9, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(nop(0, 6'b10_00_00));
    q.push_back(ins(5, 1, 2, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(6, 5, 0, 1, 0, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(9, 6, 5, 1, 1, 1, 0, 0, 6'b10_00_00));
    q.push_back(nop(0, 6'b10_01_00));
    repeat (2) q.push_back(nop(0, 6'b00_00_00));
    q.push_back(ins(0, 1, 2, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(8, 0, 0, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(nop(0, 6'b00_00_00));
    q.push_back(nop(0, 6'b00_00_00));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back(q[i].want);
      @(negedge clk);
      e = sb.pop_front();
      o = {bus.ForwardA, bus.ForwardB, bus.stall, bus.flush};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL forward[%0d] got %b want %b", i, o, e);
      end
      tick();
    end
  endtask
  task automatic test_load_use();
    row_t q[$];
    logic [5:0] e, o;
    do_reset();
    q.push_back(ins(7, 2, 0, 1, 0, 1, 1, 0, 6'b00_00_00));
    q.push_back(ins(9, 7, 3, 1, 1, 1, 0, 0, 6'b00_00_10));
    q.push_back(ins(9, 7, 3, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(nop(0, 6'b01_00_00));
    q.push_back(nop(0, 6'b00_00_00));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back(q[i].want);
      @(negedge clk);
      e = sb.pop_front();
      o = {bus.ForwardA, bus.ForwardB, bus.stall, bus.flush};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL load_use[%0d] got %b want %b", i, o, e);
      end
      tick();
    end
    n_cmp++;
    if (bus.stall_cnt !== 16'd1 || bus.flush_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL load_use_cnt got %0d/%0d want 1/0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask
  task automatic test_flush_priority();
    row_t q[$];
    logic [5:0] e, o;
    do_reset();
    q.push_back(ins(7, 2, 0, 1, 0, 1, 1, 0, 6'b00_00_00));
    q.push_back(ins(9, 7, 3, 1, 1, 1, 0, 1, 6'b00_00_01));
    q.push_back(nop(0, 6'b00_00_00));
    q.push_back(ins(5, 1, 2, 1, 1, 1, 0, 1, 6'b00_00_01));
    q.push_back(ins(8, 5, 6, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(nop(0, 6'b00_00_00));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back(q[i].want);
      @(negedge clk);
      e = sb.pop_front();
      o = {bus.ForwardA, bus.ForwardB, bus.stall, bus.flush};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL flush[%0d] got %b want %b", i, o, e);
      end
      tick();
    end
    n_cmp++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL flush_cnt got %0d/%0d want 0/2", bus.stall_cnt, bus.flush_cnt);
    end
  endtask
  task automatic test_reset_midstream();
    row_t q[$];
    logic [5:0] e, o;
    do_reset();
    q.push_back(nop(1, 6'b00_00_01));
    q.push_back(ins(5, 1, 2, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(8, 5, 6, 1, 1, 1, 0, 0, 6'b00_00_00));
    q.push_back(ins(7, 1, 0, 1, 0, 1, 1, 0, 6'b10_00_00));
    q.push_back(ins(9, 7, 3, 1, 1, 1, 0, 0, 6'b00_00_10));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back(q[i].want);
      @(negedge clk);
      e = sb.pop_front();
      o = {bus.ForwardA, bus.ForwardB, bus.stall, bus.flush};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL midstream[%0d] got %b want %b", i, o, e);
      end
      if (i < q.size() - 1) tick();
    end
    n_cmp++;
    if (bus.flush_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL pre_reset_cnt got %0d want 1", bus.flush_cnt);
    end
    rst = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ForwardA, bus.ForwardB, bus.stall, bus.flush} !== 6'd0) begin
      n_bad++;
      $display("FAIL async_reset got %b want 000000", {bus.ForwardA, bus.ForwardB, bus.stall, bus.flush});
    end
    n_cmp++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(ins(9, 7, 3, 1, 1, 1, 0, 0, 6'd0));
    #1;
    n_cmp++;
    if ({bus.ForwardA, bus.ForwardB, bus.stall, bus.flush} !== 6'd0) begin
      n_bad++;
      $display("FAIL post_reset got %b want 000000", {bus.ForwardA, bus.ForwardB, bus.stall, bus.flush});
    end
    tick();
  endtask
  task automatic test_saturation();
    do_reset();
    bus2.ex_branch_taken = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (bus2.flush_cnt !== 2'd3) begin
      n_bad++;
      $display("FAIL sat_at_3 got %0d want 3", bus2.flush_cnt);
    end
    repeat (2) tick();
    bus2.ex_branch_taken = 1'b0;
    n_cmp++;
    if (bus2.flush_cnt !== 2'd3 || bus2.stall_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL sat_after_5 got %0d/%0d want 3/0", bus2.flush_cnt, bus2.stall_cnt);
    end
  endtask
  initial begin
    drive(nop(1'b0, 6'd0));
    bus2.id_valid = 1'b0; bus2.id_rd = '0; bus2.id_rs1 = '0; bus2.id_rs2 = '0;
    bus2.id_use_rs1 = 1'b0; bus2.id_use_rs2 = 1'b0; bus2.id_regwrite = 1'b0;
    bus2.id_memread = 1'b0; bus2.ex_branch_taken = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_flush_priority();
    test_reset_midstream();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
